// File: rtl/l2_smi_controller.sv
// rtl/l2_smi_controller.sv - L2 system memory interface: writeback/load queues and 16-beat AXI bursts
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   rd_*                  request, victim line and victim tag from the L2 read stage
//   stall_pipeline        a writeback is needed but the writeback queue is full
//   smi_*                 load queue head, filled line and one-cycle reissue strobe
//   axi_*                 32-bit AXI master; 16-beat bursts, write response always accepted

module l2_smi_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enqueue,
    input  logic [WIDTH-1:0] din,
    input  logic             dequeue,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_enq;
    logic             do_deq;

    assign full   = (count == CNT_W'(DEPTH));
    assign empty  = (count == '0);
    assign do_enq = enqueue && !full;
    assign do_deq = dequeue && !empty;
    // Show-ahead: the oldest entry is visible without a read request.
    assign head   = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_enq) wr_ptr <= next_ptr(wr_ptr);
            if (do_deq) rd_ptr <= next_ptr(rd_ptr);
            case ({do_enq, do_deq})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_enq) mem[wr_ptr] <= din;
    end
endmodule

module l2_smi_controller #(
    parameter int QUEUE_DEPTH     = 12,
    parameter int PENDING_ENTRIES = 16,
    parameter int TAG_WIDTH       = 18
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 stall_pipeline,
    input  logic                 rd_l2req_valid,
    input  logic [1:0]           rd_l2req_core,
    input  logic [1:0]           rd_l2req_unit,
    input  logic [1:0]           rd_l2req_strand,
    input  logic [2:0]           rd_l2req_op,
    input  logic [1:0]           rd_l2req_way,
    input  logic [25:0]          rd_l2req_address,
    input  logic [511:0]         rd_l2req_data,
    input  logic [63:0]          rd_l2req_mask,
    input  logic                 rd_has_sm_data,
    input  logic                 rd_cache_hit,
    input  logic                 rd_line_is_dirty,
    input  logic [511:0]         rd_cache_mem_result,
    input  logic [TAG_WIDTH-1:0] rd_old_l2_tag,
    input  logic [1:0]           rd_replace_l2_way,
    output logic                 smi_duplicate_request,
    output logic [1:0]           smi_l2req_core,
    output logic [1:0]           smi_l2req_unit,
    output logic [1:0]           smi_l2req_strand,
    output logic [2:0]           smi_l2req_op,
    output logic [1:0]           smi_l2req_way,
    output logic [25:0]          smi_l2req_address,
    output logic [511:0]         smi_l2req_data,
    output logic [63:0]          smi_l2req_mask,
    output logic [511:0]         smi_load_buffer_vec,
    output logic                 smi_data_ready,
    output logic [1:0]           smi_fill_l2_way,
    output logic [31:0]          axi_awaddr,
    output logic [7:0]           axi_awlen,
    output logic                 axi_awvalid,
    input  logic                 axi_awready,
    output logic [31:0]          axi_wdata,
    output logic                 axi_wlast,
    output logic                 axi_wvalid,
    input  logic                 axi_wready,
    input  logic                 axi_bvalid,
    output logic                 axi_bready,
    output logic [31:0]          axi_araddr,
    output logic [7:0]           axi_arlen,
    output logic                 axi_arvalid,
    input  logic                 axi_arready,
    input  logic                 axi_rvalid,
    output logic                 axi_rready,
    input  logic [31:0]          axi_rdata
);
    localparam int         SET_W         = 26 - TAG_WIDTH;
    localparam int         PEND_W        = $clog2(PENDING_ENTRIES);
    localparam int         WB_W          = 26 + 512;
    localparam int         LD_W          = 616;
    localparam logic [2:0] OP_FLUSH      = 3'd2;
    localparam logic [2:0] OP_INVALIDATE = 3'd3;

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_DATA,
        RD_DONE
    } state_t;

    // Writeback queue: {victim line address, victim data}
    logic            wb_enq, wb_deq, wb_full, wb_empty;
    logic [WB_W-1:0] wb_din, wb_head;

    assign wb_enq = rd_l2req_valid && rd_line_is_dirty
                    && (rd_l2req_op == OP_FLUSH || rd_has_sm_data);
    assign wb_din = {rd_old_l2_tag, rd_l2req_address[SET_W-1:0], rd_cache_mem_result};
    assign stall_pipeline = wb_enq && wb_full;

    l2_smi_fifo #(.WIDTH(WB_W), .DEPTH(QUEUE_DEPTH)) u_wb_fifo (
        .clk     (clk),
        .reset   (reset),
        .enqueue (wb_enq),
        .din     (wb_din),
        .dequeue (wb_deq),
        .head    (wb_head),
        .full    (wb_full),
        .empty   (wb_empty)
    );

    // Load queue: the whole request plus the duplicate flag
    logic            ld_enq, ld_deq, ld_full, ld_empty, dup;
    logic [LD_W-1:0] ld_din, ld_head;

    assign ld_enq = rd_l2req_valid && !rd_cache_hit && !rd_has_sm_data
                    && rd_l2req_op != OP_FLUSH && rd_l2req_op != OP_INVALIDATE;
    assign ld_din = {dup, rd_l2req_core, rd_l2req_unit, rd_l2req_strand, rd_l2req_op,
                     rd_l2req_way, rd_replace_l2_way, rd_l2req_address, rd_l2req_data,
                     rd_l2req_mask};
    assign {smi_duplicate_request, smi_l2req_core, smi_l2req_unit, smi_l2req_strand,
            smi_l2req_op, smi_l2req_way, smi_fill_l2_way, smi_l2req_address,
            smi_l2req_data, smi_l2req_mask} = ld_head;

    // Overflow cannot happen upstream, so full is intentionally unused here.
    l2_smi_fifo #(.WIDTH(LD_W), .DEPTH(QUEUE_DEPTH)) u_ld_fifo (
        .clk     (clk),
        .reset   (reset),
        .enqueue (ld_enq),
        .din     (ld_din),
        .dequeue (ld_deq),
        .head    (ld_head),
        .full    (ld_full),
        .empty   (ld_empty)
    );

    // Outstanding-miss table: a second miss to a line already being fetched
    // is marked duplicate and later reissued from the load buffer without a read.
    logic [PENDING_ENTRIES-1:0] pend_valid;
    logic [25:0]                pend_addr [PENDING_ENTRIES];
    logic [PENDING_ENTRIES-1:0] pend_match;
    logic [PEND_W-1:0]          alloc_idx;
    logic                       alloc_ok, pend_alloc, pend_free;

    always_comb begin
        pend_match = '0;
        alloc_idx  = '0;
        alloc_ok   = 1'b0;
        for (int i = 0; i < PENDING_ENTRIES; i++) begin
            pend_match[i] = pend_valid[i] && (pend_addr[i] == rd_l2req_address);
            if (!pend_valid[i] && !alloc_ok) begin
                alloc_ok  = 1'b1;
                alloc_idx = PEND_W'(i);
            end
        end
    end

    assign dup        = ld_enq && (|pend_match);
    assign pend_alloc = ld_enq && !dup && alloc_ok;
    assign pend_free  = rd_l2req_valid && rd_has_sm_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_valid <= '0;
        end else begin
            for (int i = 0; i < PENDING_ENTRIES; i++) begin
                if (pend_alloc && alloc_idx == PEND_W'(i))
                    pend_valid[i] <= 1'b1;
                else if (pend_free && pend_match[i])
                    pend_valid[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pend_alloc) pend_addr[alloc_idx] <= rd_l2req_address;
    end

    // Burst engine
    state_t      state, state_nxt;
    logic [3:0]  beat, beat_nxt;
    logic        wait_bresp;
    logic [31:0] load_buf [16];
    logic [8:0]  wsel;

    // Word 0 of the line is the most significant 32 bits.
    assign wsel       = 9'd480 - {beat, 5'b0};
    assign axi_wdata  = wb_head[wsel +: 32];
    assign axi_awaddr = {wb_head[WB_W-1:512], 6'b0};
    assign axi_araddr = {smi_l2req_address, 6'b0};
    assign axi_awlen  = 8'd15;
    assign axi_arlen  = 8'd15;
    assign axi_bready = 1'b1;

    for (genvar g = 0; g < 16; g++) begin : g_buf
        assign smi_load_buffer_vec[511 - 32*g -: 32] = load_buf[g];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            beat       <= '0;
            wait_bresp <= 1'b0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            // Only one write may be outstanding; the next AW waits for its response.
            if (state == WR_ADDR)
                wait_bresp <= 1'b1;
            else if (axi_bvalid)
                wait_bresp <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (state == RD_DATA && axi_rvalid) load_buf[beat] <= axi_rdata;
    end

    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        axi_awvalid    = 1'b0;
        axi_wvalid     = 1'b0;
        axi_wlast      = 1'b0;
        axi_arvalid    = 1'b0;
        axi_rready     = 1'b0;
        smi_data_ready = 1'b0;
        wb_deq         = 1'b0;
        ld_deq         = 1'b0;
        case (state)
            IDLE: begin
                if (!wb_empty && !wait_bresp)
                    state_nxt = WR_ADDR;
                else if (!ld_empty)
                    state_nxt = smi_duplicate_request ? RD_DONE : RD_ADDR;
            end
            WR_ADDR: begin
                axi_awvalid = 1'b1;
                beat_nxt    = '0;
                if (axi_awready) state_nxt = WR_DATA;
            end
            WR_DATA: begin
                axi_wvalid = 1'b1;
                axi_wlast  = (beat == 4'd15);
                if (axi_wready) begin
                    beat_nxt = beat + 4'd1;
                    if (beat == 4'd15) begin
                        wb_deq    = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            RD_ADDR: begin
                axi_arvalid = 1'b1;
                beat_nxt    = '0;
                if (axi_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                axi_rready = 1'b1;
                if (axi_rvalid) begin
                    beat_nxt = beat + 4'd1;
                    if (beat == 4'd15) state_nxt = RD_DONE;
                end
            end
            RD_DONE: begin
                smi_data_ready = 1'b1;
                ld_deq         = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_l2_smi_controller.sv
// tb/tb_l2_smi_controller.sv - directed scoreboard bench for l2_smi_controller
module tb_l2_smi_controller;
    localparam int         TW       = 18;
    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_FLUSH = 3'd2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           stall_pipeline;
    logic           rd_l2req_valid;
    logic [1:0]     rd_l2req_core, rd_l2req_unit, rd_l2req_strand, rd_l2req_way, rd_replace_l2_way;
    logic [2:0]     rd_l2req_op;
    logic [25:0]    rd_l2req_address;
    logic [511:0]   rd_l2req_data;
    logic [63:0]    rd_l2req_mask;
    logic           rd_has_sm_data, rd_cache_hit, rd_line_is_dirty;
    logic [511:0]   rd_cache_mem_result;
    logic [TW-1:0]  rd_old_l2_tag;
    logic           smi_duplicate_request;
    logic [1:0]     smi_l2req_core, smi_l2req_unit, smi_l2req_strand, smi_l2req_way, smi_fill_l2_way;
    logic [2:0]     smi_l2req_op;
    logic [25:0]    smi_l2req_address;
    logic [511:0]   smi_l2req_data;
    logic [63:0]    smi_l2req_mask;
    logic [511:0]   smi_load_buffer_vec;
    logic           smi_data_ready;
    logic [31:0]    axi_awaddr, axi_araddr, axi_wdata, axi_rdata;
    logic [7:0]     axi_awlen, axi_arlen;
    logic           axi_awvalid, axi_awready, axi_wlast, axi_wvalid, axi_wready;
    logic           axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    l2_smi_controller dut (
        .clk(clk), .reset(reset), .stall_pipeline(stall_pipeline),
        .rd_l2req_valid(rd_l2req_valid), .rd_l2req_core(rd_l2req_core),
        .rd_l2req_unit(rd_l2req_unit), .rd_l2req_strand(rd_l2req_strand),
        .rd_l2req_op(rd_l2req_op), .rd_l2req_way(rd_l2req_way),
        .rd_l2req_address(rd_l2req_address), .rd_l2req_data(rd_l2req_data),
        .rd_l2req_mask(rd_l2req_mask), .rd_has_sm_data(rd_has_sm_data),
        .rd_cache_hit(rd_cache_hit), .rd_line_is_dirty(rd_line_is_dirty),
        .rd_cache_mem_result(rd_cache_mem_result), .rd_old_l2_tag(rd_old_l2_tag),
        .rd_replace_l2_way(rd_replace_l2_way),
        .smi_duplicate_request(smi_duplicate_request), .smi_l2req_core(smi_l2req_core),
        .smi_l2req_unit(smi_l2req_unit), .smi_l2req_strand(smi_l2req_strand),
        .smi_l2req_op(smi_l2req_op), .smi_l2req_way(smi_l2req_way),
        .smi_l2req_address(smi_l2req_address), .smi_l2req_data(smi_l2req_data),
        .smi_l2req_mask(smi_l2req_mask), .smi_load_buffer_vec(smi_load_buffer_vec),
        .smi_data_ready(smi_data_ready), .smi_fill_l2_way(smi_fill_l2_way),
        .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bvalid(axi_bvalid),
        .axi_bready(axi_bready), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready), .axi_rdata(axi_rdata)
    );

    typedef struct { logic [31:0] addr; logic [511:0] line; } aw_exp_t;
    typedef struct { logic [25:0] addr; logic dup; } rdy_exp_t;

    aw_exp_t      aw_q [$];
    logic [31:0]  ar_q [$];
    rdy_exp_t     rdy_q [$];
    logic [511:0] exp_buf = '0;
    logic [511:0] line_a, line_b, line_c;
    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mk_line(input logic [31:0] seed);
        logic [511:0] l;
        for (int b = 0; b < 16; b++) l[480 - 32*b +: 32] = seed + 32'(b);
        return l;
    endfunction

    task automatic push_aw(input logic [31:0] a, input logic [511:0] l);
        aw_exp_t e;
        e.addr = a;
        e.line = l;
        aw_q.push_back(e);
    endtask

    task automatic push_rdy(input logic [25:0] a, input logic d);
        rdy_exp_t e;
        e.addr = a;
        e.dup  = d;
        rdy_q.push_back(e);
    endtask

    // Called at a negedge; holds the request for one cycle.
    task automatic req(input logic [25:0] a, input logic [2:0] op, input logic hit,
                       input logic dirty, input logic sm, input logic [TW-1:0] tag,
                       input logic [511:0] victim, input logic exp_stall);
        rd_l2req_valid      = 1'b1;
        rd_l2req_address    = a;
        rd_l2req_op         = op;
        rd_cache_hit        = hit;
        rd_line_is_dirty    = dirty;
        rd_has_sm_data      = sm;
        rd_old_l2_tag       = tag;
        rd_cache_mem_result = victim;
        rd_l2req_core       = a[1:0];
        rd_replace_l2_way   = a[3:2];
        rd_l2req_data       = ~victim;
        rd_l2req_mask       = {38'd0, a};
        #1;
        chk("stall_pipeline", stall_pipeline, exp_stall);
        @(negedge clk);
        rd_l2req_valid   = 1'b0;
        rd_line_is_dirty = 1'b0;
        rd_has_sm_data   = 1'b0;
        rd_cache_hit     = 1'b0;
    endtask

    task automatic wait_ar();
        bit seen = 0;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (axi_arvalid === 1'b1) begin
                seen = 1;
                chk("ar_expected", ar_q.size() != 0, 1'b1);
                if (ar_q.size() != 0) chk("araddr", axi_araddr, ar_q.pop_front());
                chk("arlen", axi_arlen, 8'd15);
                chk("awvalid_during_ar", axi_awvalid, 1'b0);
                axi_arready = 1'b1;
                @(negedge clk);
                axi_arready = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        chk("ar_seen", seen, 1'b1);
    endtask

    task automatic do_r(input logic [31:0] base, input int nbeats);
        for (int b = 0; b < nbeats; b++) begin
            if (b == 7) begin
                axi_rvalid = 1'b0;
                @(negedge clk);
            end
            chk("rready", axi_rready, 1'b1);
            axi_rvalid = 1'b1;
            axi_rdata  = base + 32'(b);
            exp_buf[480 - 32*b +: 32] = base + 32'(b);
            @(negedge clk);
        end
        axi_rvalid = 1'b0;
    endtask

    task automatic wait_ready();
        bit seen = 0;
        rdy_exp_t e;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (smi_data_ready === 1'b1) begin
                seen = 1;
                chk("rdy_expected", rdy_q.size() != 0, 1'b1);
                if (rdy_q.size() != 0) begin
                    e = rdy_q.pop_front();
                    chk("smi_address", smi_l2req_address, e.addr);
                    chk("smi_dup", smi_duplicate_request, e.dup);
                    chk("smi_fill_way", smi_fill_l2_way, e.addr[3:2]);
                end
                chk("smi_op", smi_l2req_op, OP_LOAD);
                chk("load_buffer", smi_load_buffer_vec, exp_buf);
                @(negedge clk);
                chk("ready_single_pulse", smi_data_ready, 1'b0);
            end else begin
                @(negedge clk);
            end
        end
        chk("ready_seen", seen, 1'b1);
    endtask

    task automatic wait_aw();
        bit seen = 0;
        aw_exp_t e;
        for (int c = 0; c < 100 && !seen; c++) begin
            if (axi_awvalid === 1'b1) begin
                seen = 1;
                chk("aw_expected", aw_q.size() != 0, 1'b1);
                e = aw_q.pop_front();
                chk("awaddr", axi_awaddr, e.addr);
                chk("awlen", axi_awlen, 8'd15);
                chk("arvalid_during_aw", axi_arvalid, 1'b0);
                axi_awready = 1'b1;
                @(negedge clk);
                axi_awready = 1'b0;
                for (int b = 0; b < 16; b++) begin
                    bit acc = 0;
                    for (int g = 0; g < 8 && !acc; g++) begin
                        chk("wvalid", axi_wvalid, 1'b1);
                        chk("wdata", axi_wdata, e.line[480 - 32*b +: 32]);
                        chk("wlast", axi_wlast, b == 15);
                        acc = (g >= 2) || ($urandom_range(0, 3) != 0);
                        axi_wready = acc;
                        @(negedge clk);
                    end
                end
                axi_wready = 1'b0;
                chk("wvalid_after_burst", axi_wvalid, 1'b0);
            end else begin
                @(negedge clk);
            end
        end
        chk("aw_seen", seen, 1'b1);
    endtask

    task automatic bresp();
        axi_bvalid = 1'b1;
        @(negedge clk);
        axi_bvalid = 1'b0;
    endtask

    task automatic idle_check(input int n);
        for (int c = 0; c < n; c++) begin
            chk("no_awvalid", axi_awvalid, 1'b0);
            chk("no_arvalid", axi_arvalid, 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        rd_l2req_valid = 0; rd_l2req_core = 0; rd_l2req_unit = 2'd1; rd_l2req_strand = 0;
        rd_l2req_way = 0; rd_replace_l2_way = 0; rd_l2req_op = 0; rd_l2req_address = 0;
        rd_l2req_data = 0; rd_l2req_mask = 0; rd_has_sm_data = 0; rd_cache_hit = 0;
        rd_line_is_dirty = 0; rd_cache_mem_result = 0; rd_old_l2_tag = 0;
        axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_arready = 0;
        axi_rvalid = 0; axi_rdata = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_awvalid", axi_awvalid, 1'b0);
        chk("rst_wvalid", axi_wvalid, 1'b0);
        chk("rst_wlast", axi_wlast, 1'b0);
        chk("rst_arvalid", axi_arvalid, 1'b0);
        chk("rst_rready", axi_rready, 1'b0);
        chk("rst_data_ready", smi_data_ready, 1'b0);
        chk("rst_stall", stall_pipeline, 1'b0);
        chk("bready", axi_bready, 1'b1);
        reset = 1'b0;
        @(negedge clk);

        // Single clean miss
        ar_q.push_back(32'h0000_48C0);
        push_rdy(26'h123, 1'b0);
        req(26'h123, OP_LOAD, 0, 0, 0, '0, '0, 0);
        wait_ar();
        do_r(32'd0, 16);
        wait_ready();
        chk("t1_word0", smi_load_buffer_vec[511:480], 32'd0);
        chk("t1_word15", smi_load_buffer_vec[31:0], 32'd15);

        // Dirty victim on fill, then a flush blocked until the write response
        line_a = mk_line(32'hA000_0000);
        push_aw(32'h0000_5140, line_a);
        req({18'h2A, 8'h45}, OP_LOAD, 0, 1, 1, 18'd1, line_a, 0);
        wait_aw();
        line_b = mk_line(32'hB000_0000);
        push_aw(32'h0001_5180, line_b);
        req({18'h3, 8'h46}, OP_FLUSH, 1, 1, 0, 18'd5, line_b, 0);
        idle_check(6);
        bresp();
        wait_aw();
        bresp();

        // Duplicate misses: one read, two reissues
        ar_q.push_back(32'h0000_8000);
        push_rdy(26'h200, 1'b0);
        push_rdy(26'h200, 1'b1);
        req(26'h200, OP_LOAD, 0, 0, 0, '0, '0, 0);
        req(26'h200, OP_LOAD, 0, 0, 0, '0, '0, 0);
        wait_ar();
        do_r(32'h100, 16);
        wait_ready();
        wait_ready();
        idle_check(4);
        // The filled reissue frees the entry, so a new miss reads again
        req(26'h200, OP_LOAD, 1, 0, 1, '0, '0, 0);
        ar_q.push_back(32'h0000_8000);
        push_rdy(26'h200, 1'b0);
        req(26'h200, OP_LOAD, 0, 0, 0, '0, '0, 0);
        wait_ar();
        do_r(32'h200, 16);
        wait_ready();

        // Writeback and load both queued while a read is in flight: AW first
        ar_q.push_back(32'h0000_C000);
        push_rdy(26'h300, 1'b0);
        req(26'h300, OP_LOAD, 0, 0, 0, '0, '0, 0);
        wait_ar();
        push_rdy(26'h301, 1'b0);
        req(26'h301, OP_LOAD, 0, 0, 0, '0, '0, 0);
        line_c = mk_line(32'hC000_0000);
        push_aw(32'h0000_8400, line_c);
        req({18'h7, 8'h10}, OP_FLUSH, 1, 1, 0, 18'd2, line_c, 0);
        ar_q.push_back(32'h0000_C040);
        do_r(32'h300, 16);
        wait_ready();
        wait_aw();
        bresp();
        wait_ar();
        do_r(32'h400, 16);
        wait_ready();

        // Fill the writeback queue with AW held off; the 13th stalls
        for (int i = 0; i < 13; i++) begin
            logic [25:0] la;
            la = {18'(16 + i), 8'(i)};
            if (i < 12) push_aw({la, 6'b0}, mk_line(32'(i) << 8));
            req({18'h0, 8'(i)}, OP_FLUSH, 1, 1, 0, 18'(16 + i), mk_line(32'(i) << 8), i == 12);
        end
        repeat (12) begin
            wait_aw();
            bresp();
        end
        idle_check(5);

        // Reset in the middle of a read burst
        ar_q.push_back(32'h0001_0000);
        req(26'h400, OP_LOAD, 0, 0, 0, '0, '0, 0);
        wait_ar();
        do_r(32'h500, 5);
        reset = 1'b1;
        #1;
        chk("midrst_rready", axi_rready, 1'b0);
        chk("midrst_arvalid", axi_arvalid, 1'b0);
        chk("midrst_awvalid", axi_awvalid, 1'b0);
        chk("midrst_wvalid", axi_wvalid, 1'b0);
        chk("midrst_data_ready", smi_data_ready, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        idle_check(4);
        ar_q.push_back(32'h0001_0000);
        push_rdy(26'h400, 1'b0);
        req(26'h400, OP_LOAD, 0, 0, 0, '0, '0, 0);
        wait_ar();
        do_r(32'h600, 16);
        wait_ready();

        chk("aw_q_drained", aw_q.size(), 0);
        chk("ar_q_drained", ar_q.size(), 0);
        chk("rdy_q_drained", rdy_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule

// File: doc/l2_smi_controller.md
Name: l2_smi_controller

Overview:
- L2 cache system memory interface. Sits after the L2 read stage.
- Queues dirty-line writebacks and miss loads, and runs 16-beat AXI bursts to system memory.
- When a miss is filled it presents the original request plus the load buffer for reissue through the L2 arbiter.
- Contains three internal functions: a duplicate-miss tracker, two show-ahead FIFOs, and a 32-bit lane selector for write data.

Parameters:
QUEUE_DEPTH, 12, entries in each of the writeback and load FIFOs.
PENDING_ENTRIES, 16, entries in the outstanding-miss address table.
TAG_WIDTH, 18, width of rd_old_l2_tag; set index width = 26 - TAG_WIDTH.

Ports:
clk  in  1  clock; all state on rising edge.
reset  in  1  asynchronous, active-high.
stall_pipeline  out  1  writeback needed but writeback FIFO full.
rd_l2req_valid  in  1  request valid at read stage.
rd_l2req_core, rd_l2req_unit, rd_l2req_strand, rd_l2req_way, rd_replace_l2_way  in  2 each  request fields / way to fill.
rd_l2req_op  in  3  opcode (FLUSH, INVALIDATE encodings from l2_cache.h).
rd_l2req_address  in  26  cache-line address.
rd_l2req_data  in  512  store data.
rd_l2req_mask  in  64  byte mask.
rd_has_sm_data, rd_cache_hit, rd_line_is_dirty  in  1 each  reissued-fill flag, hit, victim dirty.
rd_cache_mem_result  in  512  victim line data.
rd_old_l2_tag  in  TAG_WIDTH  victim tag.
smi_duplicate_request, smi_l2req_core/unit/strand/op/way/address/data/mask, smi_fill_l2_way  out  as inputs  load FIFO head.
smi_load_buffer_vec  out  512  filled line; word 0 in bits 511:480.
smi_data_ready  out  1  one-cycle reissue strobe; dequeues load FIFO.
axi_awaddr, axi_araddr  out  32  {line address, 6'b0}.
axi_awlen, axi_arlen  out  8  constant 15.
axi_awvalid, axi_wvalid, axi_wlast, axi_arvalid, axi_rready, axi_bready  out  1  AXI controls; bready tied 1.
axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid  in  1  AXI handshakes.
axi_wdata  out  32  write beat.
axi_rdata  in  32  read beat.

Behaviour:
- wb_enq = valid & dirty & (op==FLUSH | has_sm_data). Entry is {tag,set_index}, rd_cache_mem_result (538 bits).
- stall_pipeline = wb_enq & wb_full. No enqueue while full.
- ld_enq = valid & !hit & !has_sm_data & op!=FLUSH & op!=INVALIDATE.
- Load FIFO entry is 616 bits, all request fields plus the dup bit. Enqueue while full is ignored (upstream guarantees no overflow).
- FIFOs are show-ahead: head visible combinationally.
  - full when count==QUEUE_DEPTH; empty when count==0.
  - Simultaneous enqueue+dequeue is legal and leaves count unchanged. Pointers wrap at QUEUE_DEPTH.
- Pending table: dup = ld_enq & address matches any valid entry (combinational).
  - ld_enq & !dup allocates a free entry.
  - valid & has_sm_data invalidates the matching entry.
  - Allocate and free in the same cycle are both applied.
- State machine states: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RD_DONE.
  - IDLE: writeback FIFO non-empty → WR_ADDR, but only if !wait_bresp. Writeback has priority over load. Otherwise load FIFO non-empty → RD_DONE if head dup, else RD_ADDR.
  - WR_ADDR: awvalid=1, beat=0; → WR_DATA on awready.
  - WR_DATA: wvalid=1, wdata = writeback head bits [511-32·beat -: 32]. On wready beat++. At beat 15: wlast=1, dequeue writeback FIFO, → IDLE.
  - RD_ADDR: arvalid=1, beat=0; → RD_DATA on arready.
  - RD_DATA: rready=1. On rvalid, buffer[beat] ← rdata and beat++. At beat 15 → RD_DONE.
  - RD_DONE: smi_data_ready=1 for exactly 1 cycle, dequeue load FIFO, → IDLE.
- wait_bresp is set when state==WR_ADDR, else cleared on bvalid; set wins.
- Reset: state IDLE, beat 0, wait_bresp 0, FIFOs empty, table invalid.
  - All AXI valids/wlast/rready and smi_data_ready read 0. Load buffer contents are undefined.
  - Reset mid-burst abandons the transaction.

Test Plan:
- Miss at address 0x0000123, clean victim → araddr 0x000048C0, arlen 15. Return rdata 0..15 → smi_data_ready pulses once; smi_load_buffer_vec[511:480]=0, [31:0]=15.
- Dirty victim on fill (has_sm_data=1, tag=1, set 0x45) → awaddr matches line, 16 wdata beats MSB word first, wlast only on beat 16; next write blocked until bvalid.
- Two misses to the same address → second has dup=1 and issues no AXI read; smi_data_ready pulses twice total.
- Writeback and load queued together → AW issued before AR.
- 12 writebacks with awready=0 → stall_pipeline=1 on the 13th; asserting awready drains the queue.
- Assert reset during RD_DATA → all valids 0, FIFOs empty, next miss starts at RD_ADDR.
